// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multicycle control FSM for the RISC-V datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, waits on a bounded memory handshake
// and traps on illegal opcodes or memory timeouts.
// Optional feature macro: RISCV_MC_PERF_EN adds cycle_cnt / instret_cnt.
module riscv_mc_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int PERF_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic        instret_pulse,
  output logic        halt,
  output logic [1:0]  trap_cause
`ifdef RISCV_MC_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  // Elaboration-time parameter sanity hooks (empty when parameters are legal).
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_mem_timeout
  end
  if (PERF_W < 1) begin : g_bad_perf_w
  end

  state_t      state_r;
  logic [7:0]  wait_cnt_r;
  logic [1:0]  cause_r;
  logic        timeout_s;
  logic        taken_s;

  // The registered count equals MEM_TIMEOUT once that many request cycles went
  // unanswered; that cycle is the last chance and mem_ready still wins in it.
  assign timeout_s = (wait_cnt_r == TIMEOUT_C) && !mem_ready;
  assign taken_s   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
  assign state     = state_r;

  // State register, memory wait counter and latched trap cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_FETCH;
      wait_cnt_r <= 8'd0;
      cause_r    <= 2'b00;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (mem_ready) begin
            state_r    <= S_DECODE;
            wait_cnt_r <= 8'd0;
          end else if (timeout_s) begin
            state_r <= S_TRAP;
            cause_r <= 2'b10;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        S_DECODE: begin
          wait_cnt_r <= 8'd0;
          case (opcode)
            OP_R, OP_I, OP_LW, OP_SW, OP_JAL: state_r <= S_EXEC;
            OP_BR: begin
              if (funct3[2:1] == 2'b00) begin
                state_r <= S_EXEC;
              end else begin
                state_r <= S_TRAP;
                cause_r <= 2'b01;
              end
            end
            default: begin
              state_r <= S_TRAP;
              cause_r <= 2'b01;
            end
          endcase
        end
        S_EXEC: begin
          case (opcode)
            OP_LW, OP_SW:       state_r <= S_MEM;
            OP_BR:              state_r <= S_FETCH;
            OP_R, OP_I, OP_JAL: state_r <= S_WB;
            default: begin
              state_r <= S_TRAP;
              cause_r <= 2'b01;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            state_r    <= (opcode == OP_LW) ? S_WB : S_FETCH;
            wait_cnt_r <= 8'd0;
          end else if (timeout_s) begin
            state_r <= S_TRAP;
            cause_r <= 2'b10;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        S_WB:    state_r <= S_FETCH;
        S_TRAP:  state_r <= S_TRAP;
        default: begin
          state_r <= S_TRAP;
          cause_r <= 2'b01;
        end
      endcase
    end
  end

  // Datapath controls decoded from the current state and inputs; all zero in reset.
  always_comb begin
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    ir_write      = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'b00;
    alu_src_b     = 1'b0;
    alu_op        = 4'b0000;
    instret_pulse = 1'b0;
    halt          = 1'b0;
    trap_cause    = 2'b00;
    if (reset) begin
      halt = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        S_EXEC: begin
          case (opcode)
            OP_R: alu_op = {funct7_5, funct3};
            OP_I: begin
              alu_op    = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
              alu_src_b = 1'b1;
            end
            OP_LW, OP_SW: alu_src_b = 1'b1;
            OP_BR: begin
              alu_op        = 4'b1000;
              pc_write      = 1'b1;
              pc_src        = taken_s ? 2'b01 : 2'b00;
              instret_pulse = 1'b1;
            end
            default: alu_op = 4'b0000;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == OP_SW);
          if (mem_ready && (opcode == OP_SW)) begin
            pc_write      = 1'b1;
            instret_pulse = 1'b1;
          end else begin
            pc_write = 1'b0;
          end
        end
        S_WB: begin
          reg_write     = 1'b1;
          pc_write      = 1'b1;
          instret_pulse = 1'b1;
          wb_sel        = (opcode == OP_LW) ? 2'b01 : ((opcode == OP_JAL) ? 2'b10 : 2'b00);
          pc_src        = (opcode == OP_JAL) ? 2'b10 : 2'b00;
        end
        S_TRAP: begin
          halt       = 1'b1;
          trap_cause = cause_r;
        end
        default: halt = 1'b0;
      endcase
    end
  end

`ifdef RISCV_MC_PERF_EN
  // Performance counters: frozen in TRAP, wrap naturally at PERF_W bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_r != S_TRAP) begin
        cycle_cnt <= cycle_cnt + PERF_W'(1);
      end
      if (instret_pulse) begin
        instret_cnt <= instret_cnt + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_mc_control.sv
// Scoreboard bench for riscv_mc_control: the driver pushes one expected
// per-instruction record built from the instruction rules; a monitor
// accumulates what the DUT did and compares on each retire or trap exit.
module tb_riscv_mc_control;
  localparam int MEM_TIMEOUT = 15;
  localparam int PERF_W      = 32;
  localparam int HOLD        = 20;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7_5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [2:0] state;
  logic pc_write, ir_write, mem_req, mem_we, mem_addr_sel, reg_write;
  logic alu_src_b, instret_pulse, halt;
  logic [1:0] pc_src, wb_sel, trap_cause;
  logic [3:0] alu_op;
`ifdef RISCV_MC_PERF_EN
  logic [PERF_W-1:0] cycle_cnt, instret_cnt;
`endif

  riscv_mc_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready), .state(state),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instret_pulse(instret_pulse), .halt(halt),
    .trap_cause(trap_cause)
`ifdef RISCV_MC_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_trap;
    int         lat;
    logic [63:0] sig;
    logic [1:0] cause;
    bit         chk_alu;
    logic [3:0] alu_op;
    logic       alu_src_b;
    int         reg_writes;
    logic [1:0] wb_sel;
    logic [1:0] pc_src;
    int         mreq_f;
    int         mreq_m;
    int         we_cycles;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endfunction

  // Reference model: what one instruction should look like end to end.
  function automatic exp_t model(logic [6:0] op, logic [2:0] f3, logic f7, logic z, int fd, int md);
    exp_t e;
    bit legal, is_mem, has_wb;
    e = '{default: '0};
    if (fd > MEM_TIMEOUT) begin
      e.is_trap = 1; e.lat = MEM_TIMEOUT + 1; e.sig = 64'h05; e.cause = 2'b10;
      return e;
    end
    legal = (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_JAL) || ((op == OP_BR) && (f3 == 3'd0 || f3 == 3'd1));
    if (!legal) begin
      e.is_trap = 1; e.lat = fd + 2; e.sig = 64'h015; e.cause = 2'b01;
      return e;
    end
    is_mem = (op == OP_LW) || (op == OP_SW);
    has_wb = (op == OP_LW) || (op == OP_R) || (op == OP_I) || (op == OP_JAL);
    if (is_mem && md > MEM_TIMEOUT) begin
      e.is_trap = 1; e.lat = fd + 3 + MEM_TIMEOUT + 1; e.sig = 64'h01235; e.cause = 2'b10;
      return e;
    end
    e.sig = 64'h012;
    if (is_mem) e.sig = (e.sig << 4) | 64'h3;
    if (has_wb) e.sig = (e.sig << 4) | 64'h4;
    e.lat = (fd + 1) + 2 + (is_mem ? md + 1 : 0) + (has_wb ? 1 : 0);
    e.chk_alu = (op != OP_JAL);
    if (op == OP_R)      begin e.alu_op = {f7, f3}; e.alu_src_b = 1'b0; end
    else if (op == OP_I) begin e.alu_op = {(f3 == 3'd5) ? f7 : 1'b0, f3}; e.alu_src_b = 1'b1; end
    else if (is_mem)     begin e.alu_op = 4'd0; e.alu_src_b = 1'b1; end
    else                 begin e.alu_op = 4'b1000; e.alu_src_b = 1'b0; end
    e.reg_writes = has_wb ? 1 : 0;
    e.wb_sel = (op == OP_LW) ? 2'b01 : ((op == OP_JAL) ? 2'b10 : 2'b00);
    if (op == OP_JAL) e.pc_src = 2'b10;
    else if (op == OP_BR) e.pc_src = (((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z)) ? 2'b01 : 2'b00;
    else e.pc_src = 2'b00;
    e.mreq_f = fd + 1;
    e.mreq_m = is_mem ? md + 1 : 0;
    e.we_cycles = (op == OP_SW) ? md + 1 : 0;
    return e;
  endfunction

  // Monitor-side observations for the instruction in flight.
  int o_lat, o_rw, o_pcw, o_irw, o_mf, o_mm, o_we, o_hold, o_bad;
  logic [63:0] o_sig;
  logic [3:0] o_alu;
  logic o_srcb, in_trap, first;
  logic [1:0] o_wb, o_pcs, o_cause;
  logic [2:0] last_state;
  int n_ret, tot_cyc;

  function automatic void clear_obs();
    o_lat = 0; o_rw = 0; o_pcw = 0; o_irw = 0; o_mf = 0; o_mm = 0; o_we = 0;
    o_hold = 0; o_bad = 0; o_sig = 64'd0; o_alu = 4'hf; o_srcb = 1'bx;
    o_wb = 2'b11; o_pcs = 2'b11; o_cause = 2'b00; in_trap = 1'b0; first = 1'b1;
    last_state = 3'd7;
  endfunction

  function automatic bit pop_exp(output exp_t e);
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: got an unexpected retire/trap, expected none pending");
      e = '{default: '0};
      return 1'b0;
    end
    e = exp_q.pop_front();
    return 1'b1;
  endfunction

  initial begin
    exp_t e;
    clear_obs(); n_ret = 0; tot_cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_outs", 64'({state, pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel,
              reg_write, wb_sel, alu_src_b, alu_op, instret_pulse, halt, trap_cause}), 64'd0);
        if (in_trap && pop_exp(e)) begin
          check("trap_kind",  64'(1), 64'(e.is_trap));
          check("trap_lat",   64'(o_lat), 64'(e.lat));
          check("trap_sig",   o_sig, e.sig);
          check("trap_cause", 64'(o_cause), 64'(e.cause));
          check("trap_hold",  64'(o_hold), 64'(HOLD));
          check("trap_quiet", 64'(o_bad), 64'd0);
        end
        clear_obs(); n_ret = 0; tot_cyc = 0;
      end else begin
        tot_cyc++;
        if (halt) begin
          if (!in_trap) begin
            in_trap = 1'b1; o_cause = trap_cause; o_sig = {o_sig[59:0], 1'b0, state};
          end
          o_hold++;
          if (mem_req || mem_we || reg_write || pc_write || ir_write || instret_pulse) o_bad++;
        end else begin
          o_lat++;
          if (first || state != last_state) o_sig = {o_sig[59:0], 1'b0, state};
          first = 1'b0; last_state = state;
          if (state == 3'd2) begin o_alu = alu_op; o_srcb = alu_src_b; end
          if (reg_write) begin o_rw++; o_wb = wb_sel; end
          if (pc_write) begin o_pcw++; o_pcs = pc_src; end
          if (ir_write) o_irw++;
          if (mem_req && !mem_addr_sel) o_mf++;
          if (mem_req && mem_addr_sel) o_mm++;
          if (mem_req && mem_we) o_we++;
          if (instret_pulse) begin
            if (pop_exp(e)) begin
              check("retire_kind", 64'(0), 64'(e.is_trap));
              check("latency",     64'(o_lat), 64'(e.lat));
              check("state_seq",   o_sig, e.sig);
              if (e.chk_alu) begin
                check("alu_op",    64'(o_alu), 64'(e.alu_op));
                check("alu_src_b", 64'(o_srcb), 64'(e.alu_src_b));
              end
              check("reg_write_cnt", 64'(o_rw), 64'(e.reg_writes));
              if (e.reg_writes != 0) check("wb_sel", 64'(o_wb), 64'(e.wb_sel));
              check("pc_write_cnt", 64'(o_pcw), 64'd1);
              check("pc_src",       64'(o_pcs), 64'(e.pc_src));
              check("ir_write_cnt", 64'(o_irw), 64'd1);
              check("fetch_req_cyc", 64'(o_mf), 64'(e.mreq_f));
              check("mem_req_cyc",   64'(o_mm), 64'(e.mreq_m));
              check("mem_we_cyc",    64'(o_we), 64'(e.we_cycles));
            end
`ifdef RISCV_MC_PERF_EN
            check("instret_cnt", 64'(instret_cnt), 64'(PERF_W'(n_ret)));
            check("cycle_cnt",   64'(cycle_cnt), 64'(PERF_W'(tot_cyc - 1)));
`endif
            n_ret++;
            clear_obs();
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic trap_hold();
    repeat (HOLD) begin
      mem_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
    do_reset();
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int fd, input int md);
    int fcnt, mcnt, guard;
    bit retired;
    fcnt = 0; mcnt = 0; guard = 0;
    exp_q.push_back(model(op, f3, f7, z, fd, md));
    opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
    forever begin
      if (halt) begin
        trap_hold();
        break;
      end
      if (mem_req) mem_ready = mem_addr_sel ? (mcnt >= md) : (fcnt >= fd);
      else mem_ready = 1'($urandom);
      #1;
      if (mem_req && !mem_ready) begin
        if (mem_addr_sel) mcnt++;
        else fcnt++;
      end
      retired = instret_pulse;
      @(posedge clk);
      #1;
      if (retired) break;
      guard++;
      if (guard > 200) begin
        n_checks++; n_fail++;
        $display("FAIL instr_bound: got no retire/trap in %0d cycles, expected one", guard);
        do_reset();
        break;
      end
    end
  endtask

  // Start an LW, then reset while it waits in MEM: nothing may retire.
  task automatic abort_lw();
    opcode = OP_LW; funct3 = 3'd2;
    repeat (4) begin
      mem_ready = mem_req && !mem_addr_sel;
      @(posedge clk);
      #1;
    end
    do_reset();
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] rop;
    int r, fd, md;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LW; ops[3] = OP_SW; ops[4] = OP_BR; ops[5] = OP_JAL;
    do_reset();
    run_instr(OP_R,   3'd0, 1'b0, 1'b0, 0, 0);   // ADD
    run_instr(OP_R,   3'd0, 1'b1, 1'b0, 0, 0);   // SUB
    run_instr(OP_I,   3'd5, 1'b1, 1'b0, 0, 0);   // SRAI
    run_instr(OP_LW,  3'd2, 1'b0, 1'b0, 0, 3);   // LW, 3 wait cycles
    run_instr(OP_BR,  3'd0, 1'b0, 1'b1, 0, 0);   // BEQ taken
    run_instr(OP_BR,  3'd1, 1'b0, 1'b1, 0, 0);   // BNE not taken
    run_instr(OP_JAL, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(OP_SW,  3'd2, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R,   3'd7, 1'b0, 1'b0, MEM_TIMEOUT, 0);  // fetch ready at the last chance
    run_instr(OP_SW,  3'd2, 1'b0, 1'b0, 1, MEM_TIMEOUT);  // store ready at the last chance
    run_instr(7'd0,   3'd0, 1'b0, 1'b0, 0, 0);            // illegal opcode
    run_instr(OP_R,   3'd0, 1'b0, 1'b0, MEM_TIMEOUT + 1, 0); // fetch timeout
    run_instr(OP_LW,  3'd2, 1'b0, 1'b0, 0, MEM_TIMEOUT + 1); // load timeout
    run_instr(OP_BR,  3'd2, 1'b0, 1'b0, 0, 0);            // bad branch funct3
    abort_lw();
    run_instr(OP_I,   3'd1, 1'b0, 1'b0, 2, 0);
    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 9);
      fd = $urandom_range(0, 2);
      md = $urandom_range(0, 2);
      if ($urandom_range(0, 19) == 0) fd = MEM_TIMEOUT + 1;
      if ($urandom_range(0, 19) == 0) md = MEM_TIMEOUT + 1;
      if (r < 6) rop = ops[r];
      else if (r == 6) rop = OP_R;
      else if (r == 7) rop = OP_I;
      else if (r == 8) begin
        rop = 7'($urandom);
        while (rop == OP_R || rop == OP_I || rop == OP_LW || rop == OP_SW || rop == OP_BR || rop == OP_JAL)
          rop = 7'($urandom);
      end else rop = OP_BR;
      run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom), fd, md);
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation time limit, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
